// File: rtl/fb_pkg.sv
// Shared types and constants for the double-banked frame buffer arbiter.
// The optional statistics counters are built only when FB_ARB_STATS_EN is defined.
package fb_pkg;

  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 12;
  localparam int FB_PIXELS = 307200;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } fb_state_e;

  typedef logic fb_bank_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fb_bank_arbiter_if.sv
// Display-read, frame-writer and memory-port signals of the frame buffer arbiter.
// Valid/ready: a write word transfers on a rising edge where wr_valid && wr_ready; wr_valid never waits on wr_ready; reads have no backpressure.
interface fb_bank_arbiter_if;
  import fb_pkg::*;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_frame_done;
  logic              vsync;
  logic [ADDR_W:0]   mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              disp_bank;

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, wr_frame_done, vsync, mem_rdata,
    output rd_data, rd_valid, wr_ready, mem_addr, mem_we, mem_wdata, disp_bank
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, wr_frame_done, vsync, mem_rdata,
    input  rd_data, rd_valid, wr_ready, mem_addr, mem_we, mem_wdata, disp_bank
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// Synchronous write FIFO holding {addr,data} entries; the caller never pushes when full or pops when empty.
// Full/empty are derived only from registered pointers.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wr_entry_t push_data_i,
  input  logic      pop_i,
  output wr_entry_t pop_data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  wr_entry_t   mem_q [DEPTH];
  logic [PW:0] wptr_q, rptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PTR_ONE;
      if (pop_i)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[PW-1:0]] <= push_data_i;
  end

  assign pop_data_o = mem_q[rptr_q[PW-1:0]];
  assign empty_o    = (wptr_q == rptr_q);
  // Same index with differing wrap bits means the ring is full.
  assign full_o     = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

endmodule

// File: rtl/fb_bank_arbiter.sv
// Single-port frame buffer arbiter: reads always win, queued writes fill idle cycles, banks swap at vsync.
// Defining FB_ARB_STATS_EN adds saturating swap-defer and write-stall counters.
module fb_bank_arbiter
  import fb_pkg::*;
#(
  parameter int MEM_RD_LAT  = 2,
  parameter int WFIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  fb_bank_arbiter_if.slave    bus_io,
  output fb_state_e           dbg_state_o
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]         stat_swap_defer_o,
  output logic [15:0]         stat_wr_stall_o
`endif
);

  fb_state_e             state_q, state_d;
  fb_bank_t              disp_bank_q, disp_bank_d;
  logic                  fifo_full, fifo_empty, push, pop, wr_ready, swap_ok;
  wr_entry_t             push_entry, pop_entry;
  logic [ADDR_W:0]       mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [MEM_RD_LAT-1:0] rd_pipe_q;
  logic                  rd_valid_q;
  logic [DATA_W-1:0]     rd_data_q;

  assign wr_ready   = !fifo_full && (state_q == RUN);
  assign push       = bus_io.wr_valid && wr_ready;
  assign pop        = !bus_io.rd_req && !fifo_empty;
  assign push_entry = {bus_io.wr_addr, bus_io.wr_data};
  // A write registered on the port this cycle still belongs to the old back bank.
  assign swap_ok    = fifo_empty && !mem_we_q;

  fb_wr_fifo #(.DEPTH(WFIFO_DEPTH)) u_wr_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (pop_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    if (bus_io.rd_req) begin
      mem_addr_d = {disp_bank_q, bus_io.rd_addr};
    end else if (pop) begin
      mem_addr_d  = {~disp_bank_q, pop_entry.addr};
      mem_we_d    = 1'b1;
      mem_wdata_d = pop_entry.data;
    end
  end

  always_comb begin
    state_d     = state_q;
    disp_bank_d = disp_bank_q;
    case (state_q)
      RUN:  if (bus_io.wr_frame_done) state_d = PEND;
      PEND: if (bus_io.vsync && swap_ok) begin
        disp_bank_d = ~disp_bank_q;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      disp_bank_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_pipe_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      disp_bank_q <= disp_bank_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pipe_q[0] <= bus_io.rd_req;
      for (int i = 1; i < MEM_RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
      rd_valid_q  <= rd_pipe_q[MEM_RD_LAT-1];
      if (rd_pipe_q[MEM_RD_LAT-1]) rd_data_q <= bus_io.mem_rdata;
    end
  end

  assign bus_io.wr_ready  = wr_ready;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_we    = mem_we_q;
  assign bus_io.mem_wdata = mem_wdata_q;
  assign bus_io.rd_valid  = rd_valid_q;
  assign bus_io.rd_data   = rd_data_q;
  assign bus_io.disp_bank = disp_bank_q;
  assign dbg_state_o      = state_q;

`ifdef FB_ARB_STATS_EN
  logic [15:0] swap_defer_cnt_q, wr_stall_cnt_q;
  logic        defer_evt, stall_evt;

  assign defer_evt = (state_q == PEND) && bus_io.vsync && !swap_ok;
  assign stall_evt = bus_io.wr_valid && !wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_defer_cnt_q <= '0;
      wr_stall_cnt_q   <= '0;
    end else begin
      if (defer_evt) swap_defer_cnt_q <= sat_inc16(swap_defer_cnt_q);
      if (stall_evt) wr_stall_cnt_q   <= sat_inc16(wr_stall_cnt_q);
    end
  end

  assign stat_swap_defer_o = swap_defer_cnt_q;
  assign stat_wr_stall_o   = wr_stall_cnt_q;
`endif

endmodule

// File: tb/tb_fb_bank_arbiter.sv
// Directed bench for fb_bank_arbiter: read table, reset, contention, deferred and simultaneous swaps.
// Stat counters are checked only when FB_ARB_STATS_EN is defined.
module tb_fb_bank_arbiter;
  import fb_pkg::*;

  localparam int W = ADDR_W + 1 + DATA_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fb_bank_arbiter_if bus ();
  fb_state_e dbg_state;
`ifdef FB_ARB_STATS_EN
  logic [15:0] stat_swap_defer, stat_wr_stall;
`endif

  fb_bank_arbiter #(.MEM_RD_LAT(2), .WFIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_io      (bus),
    .dbg_state_o (dbg_state)
`ifdef FB_ARB_STATS_EN
    ,
    .stat_swap_defer_o (stat_swap_defer),
    .stat_wr_stall_o   (stat_wr_stall)
`endif
  );

  // memory model: data for the address shown in one cycle appears in the next
  function automatic logic [DATA_W-1:0] mem_model(input logic [ADDR_W:0] a);
    if (a == 20'h012345) return 12'hABC;
    return a[11:0] ^ 12'h5A5;
  endfunction

  always @(posedge clk) bus.mem_rdata <= mem_model(bus.mem_addr);

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wr_seen  = 0;
  logic [W-1:0] exp_q[$];
  int wr_log[$];
  logic model_disp = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      wr_seen++;
      wr_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL wr_unexpected: got write 0x%0h, expected none", {bus.mem_addr, bus.mem_wdata});
      end else begin
        check("wr_order", {bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_req = 1'b0;  bus.rd_addr = '0;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.wr_frame_done = 1'b0; bus.vsync = 1'b0;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({~model_disp, a, d});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_rd_valid"},  32'(bus.rd_valid),  32'd0);
    check({tag, "_rd_data"},   32'(bus.rd_data),   32'd0);
    check({tag, "_disp_bank"}, 32'(bus.disp_bank), 32'd0);
    check({tag, "_state"},     32'(dbg_state),     32'(RUN));
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   exp_mem_addr;
    logic [DATA_W-1:0] exp_data;
  } rd_vec_t;

  rd_vec_t vecs[4];

  initial begin
    int span;
    vecs[0] = '{19'h12345, 20'h012345, 12'hABC};
    vecs[1] = '{19'h00000, 20'h000000, 12'h5A5};
    vecs[2] = '{19'h00123, 20'h000123, 12'h486};
    vecs[3] = '{19'h4AFFF, 20'h04AFFF, 12'hA5A};

    // power-on reset
    idle_inputs();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    tick();
    check("por_wr_ready", 32'(bus.wr_ready), 32'd1);

    // reset asserted in the middle of a write burst
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 19'(32'h100 + i); bus.wr_data = 12'(32'h200 + i);
      push_exp(bus.wr_addr, bus.wr_data);
      tick();
      if (i == 1) check("first_pop_timing", 32'(bus.mem_we), 32'd1);
    end
    bus.wr_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midwr");
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    check("midwr_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("midwr_disp", 32'(bus.disp_bank), 32'd0);
    tick(); tick();
    check("midwr_fifo_flushed", 32'(bus.mem_we), 32'd0);

    // single-read latency table
    foreach (vecs[k]) begin
      bus.rd_req = 1'b1; bus.rd_addr = vecs[k].addr;
      tick();
      bus.rd_req = 1'b0;
      check("rd_mem_addr", 32'(bus.mem_addr), 32'(vecs[k].exp_mem_addr));
      check("rd_mem_we", 32'(bus.mem_we), 32'd0);
      tick();
      check("rd_valid_early", 32'(bus.rd_valid), 32'd0);
      tick();
      check("rd_valid", 32'(bus.rd_valid), 32'd1);
      check("rd_data", 32'(bus.rd_data), 32'(vecs[k].exp_data));
      tick();
      check("rd_valid_late", 32'(bus.rd_valid), 32'd0);
    end

    // back-to-back reads
    for (int k = 1; k < 4; k++) begin
      bus.rd_req = 1'b1; bus.rd_addr = vecs[k].addr;
      tick();
    end
    bus.rd_req = 1'b0;
    for (int k = 1; k < 4; k++) begin
      check("b2b_valid", 32'(bus.rd_valid), 32'd1);
      check("b2b_data", 32'(bus.rd_data), 32'(vecs[k].exp_data));
      tick();
    end
    check("b2b_valid_end", 32'(bus.rd_valid), 32'd0);

    // reset with a read in flight discards it
    bus.rd_req = 1'b1; bus.rd_addr = 19'h12345;
    tick();
    bus.rd_req = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rdflush");
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rdflush_valid", 32'(bus.rd_valid), 32'd0);
    end

    // contention: reads held 20 cycles, ten words offered
    bus.rd_req = 1'b1; bus.rd_addr = 19'h00050;
    span = wr_seen;
    for (int c = 0; c < 20; c++) begin
      if (c < 10) begin
        bus.wr_valid = 1'b1;
        bus.wr_addr = 19'(32'h1000 + (c < 8 ? c : 8));
        bus.wr_data = 12'(32'h300 + (c < 8 ? c : 8));
        check("cont_wr_ready", 32'(bus.wr_ready), (c < 8) ? 32'd1 : 32'd0);
        if (c < 8) push_exp(bus.wr_addr, bus.wr_data);
      end else begin
        bus.wr_valid = 1'b0;
      end
      tick();
    end
    check("cont_full_ready", 32'(bus.wr_ready), 32'd0);
    check("cont_no_write", 32'(wr_seen - span), 32'd0);
    bus.rd_req = 1'b0;
    wr_log.delete();
    repeat (12) tick();
    check("cont_drain_count", 32'(wr_log.size()), 32'd8);
    span = (wr_log.size() >= 8) ? wr_log[7] - wr_log[0] : -1;
    check("cont_drain_consecutive", 32'(span), 32'd7);
    check("cont_drain_empty", 32'(exp_q.size()), 32'd0);
    check("cont_ready_again", 32'(bus.wr_ready), 32'd1);

    // deferred swap
    bus.rd_req = 1'b1; bus.rd_addr = 19'h00060;
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 19'(32'h2000 + i); bus.wr_data = 12'(32'h400 + i);
      push_exp(bus.wr_addr, bus.wr_data);
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.wr_frame_done = 1'b1; tick(); bus.wr_frame_done = 1'b0;
    check("defer_pend", 32'(dbg_state), 32'(PEND));
    bus.vsync = 1'b1; tick(); bus.vsync = 1'b0;
    tick();
    check("defer_no_swap", 32'(bus.disp_bank), 32'd0);
    check("defer_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("defer_still_pend", 32'(dbg_state), 32'(PEND));
    bus.wr_valid = 1'b1; bus.wr_addr = 19'h2100; bus.wr_data = 12'h777;
    tick(); tick();
    bus.wr_valid = 1'b0;
    bus.rd_req = 1'b0;
    repeat (6) tick();
    check("defer_drained", 32'(exp_q.size()), 32'd0);
    bus.vsync = 1'b1; tick(); bus.vsync = 1'b0;
    model_disp = 1'b1;
    check("defer_swap", 32'(bus.disp_bank), 32'd1);
    check("defer_run_ready", 32'(bus.wr_ready), 32'd1);
`ifdef FB_ARB_STATS_EN
    check("stat_swap_defer", 32'(stat_swap_defer), 32'd1);
    check("stat_wr_stall", 32'(stat_wr_stall), 32'd4);
`endif
    for (int i = 0; i < 2; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 19'(32'h3000 + i); bus.wr_data = 12'(32'h500 + i);
      push_exp(bus.wr_addr, bus.wr_data);
      tick();
    end
    bus.wr_valid = 1'b0;
    repeat (4) tick();
    check("newback_drained", 32'(exp_q.size()), 32'd0);
    bus.rd_req = 1'b1; bus.rd_addr = 19'h00010;
    tick();
    bus.rd_req = 1'b0;
    check("newfront_read_addr", 32'(bus.mem_addr), 32'h080010);

    // frame_done and vsync together: no swap until the next vsync
    bus.wr_frame_done = 1'b1; bus.vsync = 1'b1;
    tick();
    bus.wr_frame_done = 1'b0; bus.vsync = 1'b0;
    check("simul_no_swap", 32'(bus.disp_bank), 32'd1);
    check("simul_pend", 32'(bus.wr_ready), 32'd0);
    tick(); tick();
    bus.vsync = 1'b1; tick(); bus.vsync = 1'b0;
    model_disp = 1'b0;
    check("simul_swap", 32'(bus.disp_bank), 32'd0);
    check("simul_ready", 32'(bus.wr_ready), 32'd1);
    bus.wr_valid = 1'b1; bus.wr_addr = 19'h4000; bus.wr_data = 12'h9C3;
    push_exp(bus.wr_addr, bus.wr_data);
    tick();
    bus.wr_valid = 1'b0;
    repeat (3) tick();
    check("simul_write_bank1", 32'(exp_q.size()), 32'd0);
`ifdef FB_ARB_STATS_EN
    check("stat_swap_defer_end", 32'(stat_swap_defer), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
